// File: rtl/hough_peak_select_if.sv
// Bundle between the Hough peak selector and its controller: scan control,
// accumulator BRAM read port and the per-lane results.
interface hough_peak_select_if #(
  parameter int ADDR_BITS  = 20,
  parameter int ACCUM_BITS = 16,
  parameter int THETA_BITS = 9
);
  logic                  start;
  logic [ADDR_BITS-1:0]  accum_rd_addr;
  logic [ACCUM_BITS-1:0] accum_rd_data;
  logic signed [15:0]    left_rho_out;
  logic [THETA_BITS-1:0] left_theta_out;
  logic                  left_valid;
  logic signed [15:0]    right_rho_out;
  logic [THETA_BITS-1:0] right_theta_out;
  logic                  right_valid;
  logic                  done;

  modport master (
    output start, accum_rd_data,
    input  accum_rd_addr, left_rho_out, left_theta_out, left_valid,
           right_rho_out, right_theta_out, right_valid, done
  );

  modport slave (
    input  start, accum_rd_data,
    output accum_rd_addr, left_rho_out, left_theta_out, left_valid,
           right_rho_out, right_theta_out, right_valid, done
  );
endinterface

// File: rtl/hough_peak_select.sv
// Scans the whole Hough accumulator once per start pulse and keeps the
// strongest bin inside the left-lane and right-lane theta windows.
module hough_peak_select #(
  parameter int THETAS          = 180,
  parameter int RHO_MAX         = 1469,
  parameter int RHOS            = 2939,
  parameter int THETA_BITS      = 9,
  parameter int ACCUM_BITS      = 16,
  parameter int ADDR_BITS       = 20,
  parameter int LEFT_THETA_MIN  = 100,
  parameter int LEFT_THETA_MAX  = 160,
  parameter int RIGHT_THETA_MIN = 20,
  parameter int RIGHT_THETA_MAX = 80,
  parameter int VOTE_THRESHOLD  = 50
) (
  input logic clock,
  input logic reset,
  hough_peak_select_if.slave bus
);
  localparam int RHO_BITS = $clog2(RHOS);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t state, state_next;
  logic   accept_start;
  logic   scan_last;

  logic [THETA_BITS-1:0] theta_cnt;
  logic [RHO_BITS-1:0]   rho_cnt;
  logic [ADDR_BITS-1:0]  addr_cnt;

  logic                  tag_valid;
  logic [THETA_BITS-1:0] tag_theta;
  logic [RHO_BITS-1:0]   tag_rho;

  logic [ACCUM_BITS-1:0] left_max, right_max;
  logic [RHO_BITS-1:0]   left_rho_idx, right_rho_idx;
  logic [THETA_BITS-1:0] left_theta, right_theta;
  logic                  left_hit, right_hit;
  logic                  left_ok, right_ok;

  assign scan_last = (rho_cnt == RHO_BITS'(RHOS - 1)) &&
                     (theta_cnt == THETA_BITS'(THETAS - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // start is only honoured from IDLE or DONE; a running scan cannot be restarted
  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next   = SCAN;
          accept_start = 1'b1;
        end
      end
      SCAN:    if (scan_last) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Address walks theta fastest; the flat address tracks the counters so no multiply is needed
  always_ff @(posedge clock) begin
    if (reset || accept_start) begin
      theta_cnt <= '0;
      rho_cnt   <= '0;
      addr_cnt  <= '0;
    end else if (state == SCAN && !scan_last) begin
      addr_cnt <= addr_cnt + ADDR_BITS'(1);
      if (theta_cnt == THETA_BITS'(THETAS - 1)) begin
        theta_cnt <= '0;
        rho_cnt   <= rho_cnt + RHO_BITS'(1);
      end else begin
        theta_cnt <= theta_cnt + THETA_BITS'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid <= 1'b0;
      tag_theta <= '0;
      tag_rho   <= '0;
    end else begin
      tag_valid <= (state == SCAN);
      tag_theta <= theta_cnt;
      tag_rho   <= rho_cnt;
    end
  end

  // Strict greater-than keeps the first bin seen on ties
  assign left_hit  = tag_valid &&
                     (tag_theta >= THETA_BITS'(LEFT_THETA_MIN)) &&
                     (tag_theta <= THETA_BITS'(LEFT_THETA_MAX)) &&
                     (bus.accum_rd_data > left_max);
  assign right_hit = tag_valid &&
                     (tag_theta >= THETA_BITS'(RIGHT_THETA_MIN)) &&
                     (tag_theta <= THETA_BITS'(RIGHT_THETA_MAX)) &&
                     (bus.accum_rd_data > right_max);

  always_ff @(posedge clock) begin
    if (reset || accept_start) begin
      left_max      <= '0;
      left_rho_idx  <= '0;
      left_theta    <= '0;
      right_max     <= '0;
      right_rho_idx <= '0;
      right_theta   <= '0;
    end else begin
      if (left_hit) begin
        left_max     <= bus.accum_rd_data;
        left_rho_idx <= tag_rho;
        left_theta   <= tag_theta;
      end
      if (right_hit) begin
        right_max     <= bus.accum_rd_data;
        right_rho_idx <= tag_rho;
        right_theta   <= tag_theta;
      end
    end
  end

  // No updates happen in DONE, so results read straight from the maxima stay stable
  assign left_ok  = (state == DONE) && (left_max >= ACCUM_BITS'(VOTE_THRESHOLD));
  assign right_ok = (state == DONE) && (right_max >= ACCUM_BITS'(VOTE_THRESHOLD));

  assign bus.done            = (state == DONE);
  assign bus.accum_rd_addr   = (state == SCAN) ? addr_cnt : '0;
  assign bus.left_valid      = left_ok;
  assign bus.left_theta_out  = left_ok ? left_theta : '0;
  assign bus.left_rho_out    = left_ok ? (16'(left_rho_idx) - 16'(RHO_MAX)) : '0;
  assign bus.right_valid     = right_ok;
  assign bus.right_theta_out = right_ok ? right_theta : '0;
  assign bus.right_rho_out   = right_ok ? (16'(right_rho_idx) - 16'(RHO_MAX)) : '0;
endmodule

// File: tb/tb_hough_peak_select.sv
// Directed bench for hough_peak_select on a reduced rho range (41 bins)
// so that each full scan stays a few thousand cycles long.
module tb_hough_peak_select;
  localparam int THETAS  = 180;
  localparam int RHO_MAX = 20;
  localparam int RHOS    = 2 * RHO_MAX + 1;
  localparam int NBINS   = RHOS * THETAS;
  localparam int LATENCY = NBINS + 2;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   cycles;

  logic [15:0] mem [0:NBINS-1];

  hough_peak_select_if #(.ADDR_BITS(20), .ACCUM_BITS(16), .THETA_BITS(9)) bus ();

  hough_peak_select #(
    .THETAS(THETAS), .RHO_MAX(RHO_MAX), .RHOS(RHOS),
    .THETA_BITS(9), .ACCUM_BITS(16), .ADDR_BITS(20),
    .LEFT_THETA_MIN(100), .LEFT_THETA_MAX(160),
    .RIGHT_THETA_MIN(20), .RIGHT_THETA_MAX(80),
    .VOTE_THRESHOLD(50)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Accumulator BRAM with one-cycle read latency
  always @(posedge clock) bus.accum_rd_data <= mem[bus.accum_rd_addr];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NBINS; i++) mem[i] = '0;
  endtask

  task automatic set_bin(input int rho_idx, input int theta, input logic [15:0] votes);
    mem[rho_idx * THETAS + theta] = votes;
  endtask

  // Pulses start, optionally re-pulses it mid-scan, and measures cycles until done
  task automatic apply_stimulus(input string tag, input int poke_at);
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    cycles = 1;
    check_output({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    while (!bus.done && cycles < LATENCY + 20) begin
      @(posedge clock); #1;
      cycles++;
      bus.start = (cycles == poke_at);
    end
    bus.start = 1'b0;
    check_output({tag, "_latency"}, 32'(cycles), 32'(LATENCY));
  endtask

  task automatic check_results(input string tag,
                               input logic lv, input int lrho, input int lth,
                               input logic rv, input int rrho, input int rth);
    check_output({tag, "_done"},   32'(bus.done), 32'd1);
    check_output({tag, "_addr"},   32'(bus.accum_rd_addr), 32'd0);
    check_output({tag, "_lvalid"}, 32'(bus.left_valid), 32'(lv));
    check_output({tag, "_lrho"},   bus.left_rho_out, lrho);
    check_output({tag, "_ltheta"}, 32'(bus.left_theta_out), lth);
    check_output({tag, "_rvalid"}, 32'(bus.right_valid), 32'(rv));
    check_output({tag, "_rrho"},   bus.right_rho_out, rrho);
    check_output({tag, "_rtheta"}, 32'(bus.right_theta_out), rth);
  endtask

  task automatic check_idle_zero(input string tag);
    check_output({tag, "_done"},   32'(bus.done), 32'd0);
    check_output({tag, "_addr"},   32'(bus.accum_rd_addr), 32'd0);
    check_output({tag, "_lvalid"}, 32'(bus.left_valid), 32'd0);
    check_output({tag, "_rvalid"}, 32'(bus.right_valid), 32'd0);
    check_output({tag, "_lrho"},   bus.left_rho_out, 32'd0);
    check_output({tag, "_rtheta"}, 32'(bus.right_theta_out), 32'd0);
  endtask

  task automatic load_main_peaks();
    clear_mem();
    set_bin(5, 128, 16'd200);
    set_bin(7, 150, 16'd100);
    set_bin(30, 60, 16'd150);
    set_bin(2, 170, 16'd1000);
    set_bin(4, 90, 16'd500);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    clear_mem();
    repeat (3) @(posedge clock);
    #1;
    check_idle_zero("reset");
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check_idle_zero("idle_hold");

    $display("[TB] main peaks with out-of-window distractors");
    load_main_peaks();
    apply_stimulus("main", 0);
    check_results("main", 1'b1, -15, 128, 1'b1, 10, 60);
    repeat (5) @(posedge clock);
    #1;
    check_results("main_stable", 1'b1, -15, 128, 1'b1, 10, 60);

    $display("[TB] restart from DONE with moved right peak and a stray start");
    set_bin(30, 60, 16'd0);
    set_bin(20, 45, 16'd300);
    apply_stimulus("restart", 500);
    check_results("restart", 1'b1, -15, 128, 1'b1, 0, 45);

    $display("[TB] ties and window edges");
    clear_mem();
    set_bin(10, 110, 16'd90);
    set_bin(12, 140, 16'd90);
    set_bin(11, 161, 16'd95);
    set_bin(2, 99, 16'd95);
    set_bin(0, 80, 16'd60);
    set_bin(5, 19, 16'd80);
    set_bin(3, 81, 16'd70);
    apply_stimulus("ties", 0);
    check_results("ties", 1'b1, -10, 110, 1'b1, -20, 80);

    $display("[TB] below threshold everywhere");
    clear_mem();
    set_bin(3, 170, 16'd1000);
    set_bin(20, 40, 16'd49);
    apply_stimulus("thresh49", 0);
    check_results("thresh49", 1'b0, 0, 0, 1'b0, 0, 0);

    set_bin(20, 40, 16'd50);
    apply_stimulus("thresh50", 0);
    check_results("thresh50", 1'b0, 0, 0, 1'b1, 0, 40);

    $display("[TB] reset in the middle of a scan");
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check_output("addr_first", 32'(bus.accum_rd_addr), 32'd0);
    @(posedge clock); #1;
    check_output("addr_second", 32'(bus.accum_rd_addr), 32'd1);
    repeat (179) @(posedge clock);
    #1;
    check_output("addr_row1", 32'(bus.accum_rd_addr), 32'd180);
    repeat (819) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_idle_zero("midreset");
    repeat (6) @(posedge clock);
    #1;
    check_idle_zero("midreset_hold");
    load_main_peaks();
    apply_stimulus("after_reset", 0);
    check_results("after_reset", 1'b1, -15, 128, 1'b1, 10, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
